// File: rtl/regfile_nr1w_param_if.sv
// Bus bundle for regfile_nr1w_param: the init handshake, NRD read ports and one write port.
// The master drives requests; the slave (the register file) returns read data and init status.
interface regfile_nr1w_param_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
);
  logic                   init_req;
  logic                   init_busy;
  logic [NRD-1:0]         rd_en;
  logic [NRD*AW-1:0]      rd_adr;
  // Data vectors use [0:N-1] numbering, so bit 0 is the MSB.
  logic [0:NRD*WIDTH-1]   rd_dat;
  logic [NRD-1:0]         rd_vld;
  logic [NRD-1:0]         rd_perr;
  logic                   wr_en;
  logic [AW-1:0]          wr_adr;
  logic [0:WIDTH-1]       wr_dat;

  modport master (
    output init_req, rd_en, rd_adr, wr_en, wr_adr, wr_dat,
    input  init_busy, rd_dat, rd_vld, rd_perr
  );

  modport slave (
    input  init_req, rd_en, rd_adr, wr_en, wr_adr, wr_dat,
    output init_busy, rd_dat, rd_vld, rd_perr
  );
endinterface

// File: rtl/regfile_nr1w_param.sv
// NR-read / 1-write register file with registered reads, optional write bypass and a zeroing init sequencer.
// Define REGFILE_PARITY_EN to store one even-parity bit per entry and report it on rd_perr.
module regfile_nr1w_param #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int AW        = 5,
  parameter int NRD       = 2,
  parameter int WR_BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_nr1w_param_if.slave     bus
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);

  state_t          r_state;
  logic [AW-1:0]   r_icnt;
  logic            r_busy;

  logic [0:WIDTH-1] r_mem [DEPTH];

  logic             w_init_we;
  logic             w_user_we;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_adr;
  logic [0:WIDTH-1] w_mem_dat;

  logic [0:NRD*WIDTH-1] w_rd_dat;
  logic [NRD-1:0]       w_rd_vld;
  logic [NRD-1:0]       w_rd_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_icnt  <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_icnt == LAST) begin
            r_state <= ST_READY;
            r_icnt  <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_icnt <= r_icnt + 1'b1;
          end
        end
        ST_READY: begin
          if (bus.init_req) begin
            r_state <= ST_INIT;
            r_icnt  <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_icnt  <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.init_busy = r_busy;

  // The sequencer owns the single write port while in INIT; user writes are only taken in READY.
  assign w_init_we = rst_n & (r_state == ST_INIT);
  assign w_user_we = (r_state == ST_READY) & bus.wr_en & ({1'b0, bus.wr_adr} < DEPTH_X);
  assign w_mem_we  = w_init_we | w_user_we;
  assign w_mem_adr = w_init_we ? r_icnt : bus.wr_adr;
  assign w_mem_dat = w_init_we ? '0 : bus.wr_dat;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_adr] <= w_mem_dat;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_par[w_mem_adr] <= ^w_mem_dat;
    end
  end
`endif

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]    w_adr;
    logic             w_in_rng;
    logic             w_byp;
    logic [0:WIDTH-1] w_dat;
    logic             w_perr;
    logic             w_take;
    logic [0:WIDTH-1] r_dat;
    logic             r_vld;
    logic             r_perr;

    assign w_adr    = bus.rd_adr[gi*AW +: AW];
    assign w_in_rng = ({1'b0, w_adr} < DEPTH_X);
    assign w_byp    = (WR_BYPASS != 0) && w_user_we && (bus.wr_adr == w_adr);
    assign w_take   = (r_state == ST_READY) && bus.rd_en[gi];

    // Out-of-range reads return zero; a bypassed read carries wr_dat, whose parity is self-consistent.
    always_comb begin
      w_dat  = '0;
      w_perr = 1'b0;
      if (w_in_rng) begin
        if (w_byp) begin
          w_dat = bus.wr_dat;
        end else begin
          w_dat = r_mem[w_adr];
`ifdef REGFILE_PARITY_EN
          w_perr = (^r_mem[w_adr]) ^ r_par[w_adr];
`endif
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dat  <= '0;
        r_vld  <= 1'b0;
        r_perr <= 1'b0;
      end else begin
        r_vld <= w_take;
        if (w_take) begin
          r_dat  <= w_dat;
          r_perr <= w_perr;
        end else begin
          r_perr <= 1'b0;
        end
      end
    end

    assign w_rd_dat[gi*WIDTH +: WIDTH] = r_dat;
    assign w_rd_vld[gi]                = r_vld;
    assign w_rd_perr[gi]               = r_perr;
  end

  assign bus.rd_dat  = w_rd_dat;
  assign bus.rd_vld  = w_rd_vld;
  assign bus.rd_perr = w_rd_perr;

endmodule

// File: tb/tb_regfile_nr1w_param.sv
// Scoreboard bench for regfile_nr1w_param at DEPTH=24 (non power of two), two read ports, bypass on.
// Reads push hand-computed expectations; a negedge monitor pops them whenever rd_vld is seen.
module tb_regfile_nr1w_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  typedef struct packed {
    logic [31:0] dat;
    logic        perr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  exp_t q0[$];
  exp_t q1[$];

  regfile_nr1w_param_if #(.WIDTH(WIDTH), .AW(AW), .NRD(NRD)) bus ();

  regfile_nr1w_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NRD(NRD), .WR_BYPASS(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.init_req = 1'b0;
    bus.rd_en    = '0;
    bus.wr_en    = 1'b0;
  endtask

  task automatic set_rd(int p, logic [AW-1:0] adr, logic [31:0] d, logic perr);
    exp_t e;
    e.dat  = d;
    e.perr = perr;
    bus.rd_en[p] = 1'b1;
    bus.rd_adr[p*AW +: AW] = adr;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic do_wr(logic [AW-1:0] adr, logic [31:0] d);
    bus.wr_en  = 1'b1;
    bus.wr_adr = adr;
    bus.wr_dat = d;
    step();
    bus.wr_en  = 1'b0;
  endtask

  // Counts cycles from the current negedge until init_busy falls.
  task automatic busy_run(string name);
    int n;
    n = 0;
    while (bus.init_busy && n < 200) begin
      step();
      n++;
    end
    chk(name, n, DEPTH);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, AW'(a), 32'h0, 1'b0);
      set_rd(1, AW'(DEPTH-1-a), 32'h0, 1'b0);
      step();
    end
    idle();
  endtask

  // Monitor: every rd_vld pops the oldest expectation of that port.
  always @(negedge clk) begin
    for (int p = 0; p < NRD; p++) begin
      if (bus.rd_vld[p]) begin
        exp_t e;
        logic [31:0] d;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
          n_chk++;
          $display("FAIL unexpected_vld p%0d: got vld=1, want no read pending", p);
        end else begin
          e = (p == 0) ? q0.pop_front() : q1.pop_front();
          d = bus.rd_dat[p*WIDTH +: WIDTH];
          $display("rd p%0d data=%h perr=%b (want %h/%b)", p, d, bus.rd_perr[p], e.dat, e.perr);
          chk($sformatf("rd_dat_p%0d", p), d, e.dat);
          chk($sformatf("rd_perr_p%0d", p), {31'h0, bus.rd_perr[p]}, {31'h0, e.perr});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.rd_adr = '0;
    bus.wr_adr = '0;
    bus.wr_dat = '0;
    idle();
    repeat (3) step();
    chk("reset_busy", {31'h0, bus.init_busy}, 32'h1);
    chk("reset_vld", {30'h0, bus.rd_vld}, 32'h0);
    chk("reset_dat_p0", bus.rd_dat[0:31], 32'h0);

    // Release; init_req, reads and a write issued during INIT must all be ignored.
    rst_n = 1'b1;
    n = 0;
    while (bus.init_busy && n < 200) begin
      idle();
      if (n == 3) bus.init_req = 1'b1;
      if (n == 5) begin
        bus.rd_en  = 2'b11;
        bus.rd_adr = {5'd1, 5'd0};
      end
      if (n == 20) begin
        bus.wr_en  = 1'b1;
        bus.wr_adr = 5'd2;
        bus.wr_dat = 32'h11111111;
      end
      step();
      n++;
    end
    idle();
    chk("init_busy_cycles", n, DEPTH);
    read_all_zero();
    set_rd(0, 5'd31, 32'h0, 1'b0);
    set_rd(1, 5'd24, 32'h0, 1'b0);
    step();
    idle();

    // Basic write, 1-cycle read, then hold with rd_vld low.
    do_wr(5'd5, 32'hDEADBEEF);
    set_rd(0, 5'd5, 32'hDEADBEEF, 1'b0);
    step();
    idle();
    step();
    chk("hold_vld_p0", {31'h0, bus.rd_vld[0]}, 32'h0);
    chk("hold_dat_p0", bus.rd_dat[0:31], 32'hDEADBEEF);

    // Same-cycle write and read of entry 7 on both ports returns the new data.
    do_wr(5'd7, 32'h0000FFFF);
    bus.wr_en  = 1'b1;
    bus.wr_adr = 5'd7;
    bus.wr_dat = 32'h12345678;
    set_rd(0, 5'd7, 32'h12345678, 1'b0);
    set_rd(1, 5'd7, 32'h12345678, 1'b0);
    step();
    idle();
    set_rd(0, 5'd5, 32'hDEADBEEF, 1'b0);
    set_rd(1, 5'd7, 32'h12345678, 1'b0);
    step();
    idle();

    // Out-of-range writes are dropped; the last real entry works.
    do_wr(5'd30, 32'hA5A5A5A5);
    do_wr(5'd24, 32'h5A5A5A5A);
    set_rd(0, 5'd30, 32'h0, 1'b0);
    set_rd(1, 5'd6, 32'h0, 1'b0);
    step();
    idle();
    do_wr(5'd23, 32'hCAFEF00D);
    set_rd(0, 5'd23, 32'hCAFEF00D, 1'b0);
    set_rd(1, 5'd0, 32'h0, 1'b0);
    step();
    idle();

`ifdef REGFILE_PARITY_EN
    do_wr(5'd3, 32'h00000001);
    force u_dut.r_mem[3] = 32'h00000000;
    set_rd(0, 5'd3, 32'h0, 1'b1);
    step();
    idle();
    release u_dut.r_mem[3];
`else
    do_wr(5'd3, 32'h00000001);
    set_rd(0, 5'd3, 32'h00000001, 1'b0);
    step();
    idle();
`endif

    // Fill, then init_req (with a concurrent write) clears everything.
    for (int a = 0; a < DEPTH; a++) do_wr(AW'(a), 32'hFFFFFFFF);
    set_rd(0, 5'd10, 32'hFFFFFFFF, 1'b0);
    step();
    idle();
    bus.init_req = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_adr   = 5'd4;
    bus.wr_dat   = 32'h00001234;
    step();
    idle();
    busy_run("init_req_busy_cycles");
    read_all_zero();

    // Refill, restart init, and pull rst_n once icnt has reached 10.
    for (int a = 0; a < DEPTH; a++) do_wr(AW'(a), 32'hFFFFFFFF);
    set_rd(0, 5'd10, 32'hFFFFFFFF, 1'b0);
    step();
    idle();
    bus.init_req = 1'b1;
    step();
    idle();
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("midinit_rst_busy", {31'h0, bus.init_busy}, 32'h1);
    chk("midinit_rst_vld", {30'h0, bus.rd_vld}, 32'h0);
    chk("midinit_rst_dat_p0", bus.rd_dat[0:31], 32'h0);
    step();
    rst_n = 1'b1;
    busy_run("rst_restart_busy_cycles");
    set_rd(0, 5'd0, 32'h0, 1'b0);
    set_rd(1, 5'd23, 32'h0, 1'b0);
    step();
    set_rd(0, 5'd10, 32'h0, 1'b0);
    set_rd(1, 5'd11, 32'h0, 1'b0);
    step();
    idle();

    step();
    step();
    chk("scoreboard_drained", q0.size() + q1.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
